vec_mold_iter: RTL and testbench



---
 rtl/vec_mold_pkg.sv | 24 ++
 rtl/vec_mold_iter_isqrt_step.sv | 43 ++++
 rtl/vec_mold_iter.sv | 149 ++++++++++++++
 tb/tb_vec_mold_iter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vec_mold_pkg.sv
// Shared definitions for the vector-magnitude block.
//   state_t : control states of the iterative magnitude engine
//   sum_w   : width of the sum of squares for a given component width
//   cnt_w   : width of the root-bit counter for a given component width
package vec_mold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ROOT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Sum of three squared W-bit magnitudes fits in 2W bits.
  function automatic int sum_w(input int w);
    return 32'sd2 * w;
  endfunction

  // Counter holds W-1 down to 0; keep at least one bit.
  function automatic int cnt_w(input int w);
    return (w > 32'sd2) ? $clog2(w) : 32'sd1;
  endfunction

endpackage

// File: rtl/vec_mold_iter_isqrt_step.sv
// Module isqrt_step: one combinational restoring square-root iteration.
// Ports:
//   rem      : partial remainder (W+2 bits)
//   root     : partial root (W bits)
//   pair     : next two bits of the radicand, MSB first
//   rem_nxt  : updated remainder
//   root_nxt : updated root with one new bit appended
module isqrt_step
  import vec_mold_pkg::*;
#(
  parameter int W = 20
) (
  input  logic [W+1:0] rem,
  input  logic [W-1:0] root,
  input  logic [1:0]   pair,
  output logic [W+1:0] rem_nxt,
  output logic [W-1:0] root_nxt
);

  logic [W+3:0] shifted_s;
  logic [W+3:0] trial_s;
  logic [W+3:0] diff_s;
  logic         unused_s;

  // Trial subtraction of (4*root + 1) from (4*rem + pair).
  always_comb begin
    shifted_s = {rem, pair};
    trial_s   = {2'b00, root, 2'b01};
    diff_s    = shifted_s - trial_s;
    if (shifted_s >= trial_s) begin
      rem_nxt  = diff_s[W+1:0];
      root_nxt = {root[W-2:0], 1'b1};
    end else begin
      rem_nxt  = shifted_s[W+1:0];
      root_nxt = {root[W-2:0], 1'b0};
    end
  end

  // The remainder never exceeds 2*root, so the top bits and the root MSB
  // (always zero before the final iteration) carry no information.
  assign unused_s = ^{diff_s[W+3:W+2], shifted_s[W+3:W+2], root[W-1]};

endmodule

// File: rtl/vec_mold_iter.sv
// Module vec_mold_iter: |v| = isqrt(x^2 + y^2 + z^2) of a signed 3-vector,
// one root bit per clock, with valid/ready handshakes and a pass-through tag.
// Optional macro VEC_MOLD_ROUND_EN: round the result to nearest instead of floor.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake; in_x/in_y/in_z signed components, in_tag id
//   out_valid/out_ready: output handshake; out_mold magnitude, out_tag id
module vec_mold_iter
  import vec_mold_pkg::*;
#(
  parameter int W     = 20,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [W-1:0]     in_z,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_mold,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = sum_w(W);
  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  state_t           state_r;
  logic [W-1:0]     x_r, y_r, z_r;
  logic [TAG_W-1:0] tag_r;
  logic [SW-1:0]    sum_r;
  logic [W+1:0]     rem_r;
  logic [W-1:0]     root_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [W-1:0]     out_mold_r;
  logic [TAG_W-1:0] out_tag_r;

  logic [W-1:0]     ax_s, ay_s, az_s;
  logic [SW-1:0]    sum_s;
  logic [W+1:0]     rem_nxt_s;
  logic [W-1:0]     root_nxt_s;
  logic [W-1:0]     result_s;

  // Magnitudes as W-bit unsigned: -2^(W-1) maps to 2^(W-1), which still fits.
  always_comb begin
    ax_s  = x_r[W-1] ? (~x_r + W'(1)) : x_r;
    ay_s  = y_r[W-1] ? (~y_r + W'(1)) : y_r;
    az_s  = z_r[W-1] ? (~z_r + W'(1)) : z_r;
    sum_s = (SW'(ax_s) * SW'(ax_s)) + (SW'(ay_s) * SW'(ay_s)) + (SW'(az_s) * SW'(az_s));
  end

  // Radicand is shifted left two bits per iteration, so its top pair is always next.
  isqrt_step #(.W(W)) u_step (
    .rem      (rem_r),
    .root     (root_r),
    .pair     (sum_r[SW-1:SW-2]),
    .rem_nxt  (rem_nxt_s),
    .root_nxt (root_nxt_s)
  );

  // Final result selection; rounding cannot overflow since floor root <= 2^W-2.
  always_comb begin
`ifdef VEC_MOLD_ROUND_EN
    if (rem_nxt_s > {2'b00, root_nxt_s}) begin
      result_s = root_nxt_s + W'(1);
    end else begin
      result_s = root_nxt_s;
    end
`else
    result_s = root_nxt_s;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_mold_r  <= '0;
      out_tag_r   <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      tag_r       <= '0;
      sum_r       <= '0;
      rem_r       <= '0;
      root_r      <= '0;
      cnt_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r        <= in_x;
            y_r        <= in_y;
            z_r        <= in_z;
            tag_r      <= in_tag;
            in_ready_r <= 1'b0;
            state_r    <= LOAD;
          end
        end
        LOAD: begin
          sum_r   <= sum_s;
          rem_r   <= '0;
          root_r  <= '0;
          cnt_r   <= CNT_INIT;
          state_r <= ROOT;
        end
        ROOT: begin
          rem_r  <= rem_nxt_s;
          root_r <= root_nxt_s;
          sum_r  <= sum_r << 2'd2;
          if (cnt_r == '0) begin
            out_mold_r  <= result_s;
            out_tag_r   <= tag_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_mold  = out_mold_r;
  assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_vec_mold_iter.sv
// Directed and random checks of vec_mold_iter (W=20, TAG_W=8).
// Latency is counted in rising edges starting with the accepting edge.
module tb_vec_mold_iter;

  localparam int W     = 20;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x, in_y, in_z;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_mold;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  vec_mold_iter #(.W(W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mold  (out_mold),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Golden integer square root (float estimate, then corrected).
  function automatic longint model(input longint s);
    longint r;
    r = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
`ifdef VEC_MOLD_ROUND_EN
    if (s - r * r > r) r++;
`endif
    return r;
  endfunction

  // Present one vector from IDLE, wait for the result, check it.
  // Completes the output handshake only when out_ready is high.
  task automatic run_vec(input int x, input int y, input int z, input logic [7:0] tag,
                         input longint exp, input bit chk_lat, input string name);
    int n;
    in_x = x[W-1:0];
    in_y = y[W-1:0];
    in_z = z[W-1:0];
    in_tag = tag;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 200);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    if (chk_lat) check({name, "_latency"}, 64'(n), 64'(W + 2));
    check({name, "_mold"}, 64'(out_mold), exp);
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    int rx, ry, rz;
    longint s;

    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_z = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_mold", 64'(out_mold), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_vec(3, 4, 0, 8'h5A, 64'd5, 1'b1, "v340");
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_mold_held", 64'(out_mold), 64'd5);
`ifdef VEC_MOLD_ROUND_EN
    run_vec(1, 1, 1, 8'h11, 64'd2, 1'b1, "v111");
`else
    run_vec(1, 1, 1, 8'h11, 64'd1, 1'b1, "v111");
`endif
    run_vec(0, 0, 0, 8'h22, 64'd0, 1'b1, "v000");
    run_vec(-524288, -524288, -524288, 8'hC3, 64'd908093, 1'b1, "vmin");

    // Backpressure: hold DONE for 50 cycles with a stray in_valid pulse.
    out_ready = 1'b0;
    run_vec(2, 3, 6, 8'h33, 64'd7, 1'b1, "bp");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        in_valid = 1'b1;
        in_x = 20'd99;
        in_tag = 8'hEE;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (out_mold !== 20'd7 || out_tag !== 8'h33 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    check("bp_hold_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    run_vec(-7, 0, 24, 8'h44, 64'd25, 1'b1, "after_bp");

    // Reset while iterating: the in-flight vector must vanish.
    in_x = 20'd9;
    in_y = 20'd12;
    in_z = 20'd20;
    in_tag = 8'h77;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_mold", 64'(out_mold), 64'd0);
    bad = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("midrst_no_result", 64'(bad), 64'd0);
    run_vec(6, 8, 0, 8'h88, 64'd10, 1'b1, "v680");

    // Random signed vectors against the golden model, tags in sequence.
    for (int i = 0; i < 300; i++) begin
      rx = int'($urandom_range(2 ** W - 1, 0)) - 2 ** (W - 1);
      ry = int'($urandom_range(2 ** W - 1, 0)) - 2 ** (W - 1);
      rz = int'($urandom_range(2 ** W - 1, 0)) - 2 ** (W - 1);
      s = longint'(rx) * rx + longint'(ry) * ry + longint'(rz) * rz;
      run_vec(rx, ry, rz, i[7:0], model(s), (i < 4), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
